// File: rtl/sp_chunk_seq.sv
// Secure load/store chunk sequencer: walks NUM_CHUNKS strided offsets through the
// issue stage and brackets them with cipher start/finish handshakes and a wait timeout.
`timescale 1ns/1ps

module sp_chunk_seq #(
    parameter int unsigned NUM_CHUNKS   = 5,
    parameter int unsigned CHUNK_STRIDE = 8,
    parameter int unsigned OFFSET_W     = 12,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned TIMEOUT_CYC  = 64
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_valid_i,
    input  logic                req_store_i,
    input  logic [OFFSET_W-1:0] req_offset_i,
    input  logic                issue_ack_i,
    input  logic                busy_i,
    input  logic                encrypting_i,
    input  logic                decrypting_i,
    input  logic                fail_i,
    input  logic [DATA_W-1:0]   cipher_data_i,
    output logic                req_ready_o,
    output logic                fetch_stall_o,
    output logic [OFFSET_W-1:0] offset_o,
    output logic [3:0]          chunk_idx_o,
    output logic                encrypt_en_o,
    output logic                decrypt_en_o,
    output logic                store_en_o,
    output logic                done_o,
    output logic                fail_o,
    output logic                timeout_o,
    output logic [DATA_W-1:0]   data_o
);

    localparam int unsigned IDX_W = 4;
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(NUM_CHUNKS - 1);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [OFFSET_W-1:0] STRIDE   = OFFSET_W'(CHUNK_STRIDE);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_CIPHER,
        ST_LOAD,
        ST_DEC_START,
        ST_DECRYPT,
        ST_ENC_START,
        ST_STORE,
        ST_RESP
    } state_e;

    state_e              state_q, state_d;
    logic                store_q, store_d;
    logic [OFFSET_W-1:0] base_q, base_d;
    logic [OFFSET_W-1:0] offset_q, offset_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                fail_q, fail_d;
    logic                tmo_q, tmo_d;
    logic                expire;

    // State and datapath registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            store_q  <= 1'b0;
            base_q   <= '0;
            offset_q <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            fail_q   <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            store_q  <= store_d;
            base_q   <= base_d;
            offset_q <= offset_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            fail_q   <= fail_d;
            tmo_q    <= tmo_d;
        end
    end

    // Next-state logic; the wait counter restarts whenever a timed state is (re)entered
    always_comb begin
        state_d  = state_q;
        store_d  = store_q;
        base_d   = base_q;
        offset_d = offset_q;
        idx_d    = idx_q;
        cnt_d    = '0;
        data_d   = data_q;
        fail_d   = fail_q;
        tmo_d    = tmo_q;
        expire   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    store_d  = req_store_i;
                    base_d   = req_offset_i;
                    offset_d = req_offset_i;
                    idx_d    = '0;
                    data_d   = '0;
                    fail_d   = 1'b0;
                    tmo_d    = 1'b0;
                    if (busy_i)           state_d = ST_WAIT_CIPHER;
                    else if (req_store_i) state_d = ST_ENC_START;
                    else                  state_d = ST_LOAD;
                end
            end
            ST_WAIT_CIPHER: begin
                if (!busy_i)                state_d = store_q ? ST_ENC_START : ST_LOAD;
                else if (cnt_q == CNT_LAST) expire  = 1'b1;
                else                        cnt_d   = cnt_q + CNT_W'(1);
            end
            ST_LOAD, ST_STORE: begin
                if (issue_ack_i) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = (state_q == ST_LOAD) ? ST_DEC_START : ST_RESP;
                    end else begin
                        idx_d    = idx_q + IDX_W'(1);
                        offset_d = offset_q + STRIDE;
                    end
                end
            end
            ST_DEC_START: begin
                if (decrypting_i)           state_d = ST_DECRYPT;
                else if (cnt_q == CNT_LAST) expire  = 1'b1;
                else                        cnt_d   = cnt_q + CNT_W'(1);
            end
            ST_DECRYPT: begin
                if (!decrypting_i) begin
                    state_d = ST_RESP;
                    data_d  = fail_i ? '0 : cipher_data_i;
                    fail_d  = fail_i;
                end else if (cnt_q == CNT_LAST) begin
                    expire = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_ENC_START: begin
                if (encrypting_i) begin
                    state_d  = ST_STORE;
                    idx_d    = '0;
                    offset_d = base_q;
                end else if (cnt_q == CNT_LAST) begin
                    expire = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (issue_ack_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (expire) begin
            state_d = ST_RESP;
            tmo_d   = 1'b1;
            fail_d  = 1'b1;
            data_d  = '0;
        end
    end

    // Status decode straight off the state register; stall also covers the accept cycle
    assign req_ready_o   = (state_q == ST_IDLE);
    assign fetch_stall_o = (state_q == ST_IDLE) ? req_valid_i : (state_q != ST_RESP);
    assign encrypt_en_o  = (state_q == ST_ENC_START);
    assign decrypt_en_o  = (state_q == ST_DEC_START);
    assign store_en_o    = (state_q == ST_STORE);
    assign done_o        = (state_q == ST_RESP);
    assign offset_o      = offset_q;
    assign chunk_idx_o   = idx_q;
    assign data_o        = data_q;
    assign fail_o        = fail_q;
    assign timeout_o     = tmo_q;

endmodule

// File: tb/tb_sp_chunk_seq.sv
// Directed plus randomized transactions for sp_chunk_seq against a transaction-level model.
`timescale 1ns/1ps

module tb_sp_chunk_seq;

    localparam int unsigned N      = 5;
    localparam int unsigned STRIDE = 8;
    localparam int unsigned OW     = 12;
    localparam int unsigned DW     = 32;
    localparam int unsigned TMO    = 64;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          req_valid_i, req_store_i, issue_ack_i;
    logic [OW-1:0] req_offset_i;
    logic          busy_i, encrypting_i, decrypting_i, fail_i;
    logic [DW-1:0] cipher_data_i;
    logic          req_ready_o, fetch_stall_o, encrypt_en_o, decrypt_en_o, store_en_o;
    logic          done_o, fail_o, timeout_o;
    logic [OW-1:0] offset_o;
    logic [3:0]    chunk_idx_o;
    logic [DW-1:0] data_o;

    int n_cmp = 0;
    int n_err = 0;

    sp_chunk_seq #(
        .NUM_CHUNKS(N), .CHUNK_STRIDE(STRIDE), .OFFSET_W(OW), .DATA_W(DW), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_store_i(req_store_i), .req_offset_i(req_offset_i),
        .issue_ack_i(issue_ack_i), .busy_i(busy_i), .encrypting_i(encrypting_i),
        .decrypting_i(decrypting_i), .fail_i(fail_i), .cipher_data_i(cipher_data_i),
        .req_ready_o(req_ready_o), .fetch_stall_o(fetch_stall_o), .offset_o(offset_o),
        .chunk_idx_o(chunk_idx_o), .encrypt_en_o(encrypt_en_o), .decrypt_en_o(decrypt_en_o),
        .store_en_o(store_en_o), .done_o(done_o), .fail_o(fail_o), .timeout_o(timeout_o),
        .data_o(data_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Model: chunk i of a transfer sits at base + i*stride, wrapping at 2^OW
    function automatic logic [OW-1:0] exp_off(input logic [OW-1:0] base, input int i);
        return OW'((int'(base) + i * int'(STRIDE)) % (1 << OW));
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Requests and acks arriving while busy must be ignored
    task automatic noise();
        req_valid_i  = 1'($urandom);
        req_store_i  = 1'($urandom);
        req_offset_i = OW'($urandom);
        issue_ack_i  = 1'($urandom);
    endtask

    task automatic check_busy(input string tag, input logic enc, input logic dec, input logic st);
        chk({tag, "_stall"}, fetch_stall_o, 1);
        chk({tag, "_ready"}, req_ready_o, 0);
        chk({tag, "_done"}, done_o, 0);
        chk({tag, "_enc"}, encrypt_en_o, enc);
        chk({tag, "_dec"}, decrypt_en_o, dec);
        chk({tag, "_st"}, store_en_o, st);
    endtask

    task automatic accept(input logic st, input logic [OW-1:0] base, input int busy_cyc);
        req_valid_i  = 1'b1;
        req_store_i  = st;
        req_offset_i = base;
        busy_i       = (busy_cyc > 0);
        issue_ack_i  = 1'($urandom);
        #1;
        chk("idle_ready", req_ready_o, 1);
        chk("idle_stall", fetch_stall_o, 1);
        step();
        req_valid_i = 1'b0;
        issue_ack_i = 1'b0;
        chk("clr_data", data_o, 0);
        chk("clr_fail", fail_o, 0);
        chk("clr_tmo", timeout_o, 0);
        for (int k = 0; k < busy_cyc; k++) begin
            noise();
            busy_i = (k < busy_cyc - 1);
            #1;
            check_busy("wait", 0, 0, 0);
            step();
        end
        busy_i = 1'b0;
    endtask

    task automatic chunks(input logic st, input logic [OW-1:0] base, input logic full_ack);
        int i    = 0;
        int miss = 0;
        logic ack;
        while (i < int'(N)) begin
            noise();
            ack = full_ack || ($urandom_range(0, 3) != 0) || (miss >= 3);
            issue_ack_i = ack;
            #1;
            chk("chunk_off", offset_o, exp_off(base, i));
            chk("chunk_idx", chunk_idx_o, i);
            check_busy(st ? "store" : "load", 0, 0, st);
            step();
            if (ack) begin
                i++;
                miss = 0;
            end else begin
                miss++;
            end
        end
        issue_ack_i = 1'b0;
    endtask

    task automatic decrypt(input int dly, input int hold, input logic fl, input logic [DW-1:0] d);
        for (int k = 0; k < dly; k++) begin
            noise();
            decrypting_i = 1'b0;
            #1;
            check_busy("dec_start", 0, 1, 0);
            step();
        end
        noise();
        decrypting_i = 1'b1;
        #1;
        check_busy("dec_start", 0, 1, 0);
        step();
        for (int k = 0; k < hold; k++) begin
            noise();
            cipher_data_i = DW'($urandom);
            #1;
            check_busy("decrypt", 0, 0, 0);
            step();
        end
        decrypting_i  = 1'b0;
        fail_i        = fl;
        cipher_data_i = d;
        #1;
        check_busy("decrypt", 0, 0, 0);
        step();
        fail_i        = 1'b0;
        cipher_data_i = DW'($urandom);
    endtask

    task automatic encrypt(input int dly);
        for (int k = 0; k < dly; k++) begin
            noise();
            encrypting_i = 1'b0;
            #1;
            check_busy("enc_start", 1, 0, 0);
            step();
        end
        noise();
        encrypting_i = 1'b1;
        #1;
        check_busy("enc_start", 1, 0, 0);
        step();
        encrypting_i = 1'b0;
    endtask

    task automatic resp(input logic [DW-1:0] d, input logic fl, input logic tmo);
        int hold = int'($urandom_range(0, 2));
        for (int k = 0; k <= hold; k++) begin
            noise();
            issue_ack_i = (k == hold);
            #1;
            chk("resp_done", done_o, 1);
            chk("resp_data", data_o, d);
            chk("resp_fail", fail_o, fl);
            chk("resp_tmo", timeout_o, tmo);
            chk("resp_stall", fetch_stall_o, 0);
            chk("resp_en", {encrypt_en_o, decrypt_en_o, store_en_o}, 0);
            step();
        end
        req_valid_i = 1'b0;
        issue_ack_i = 1'b0;
        #1;
        chk("back_ready", req_ready_o, 1);
        chk("back_done", done_o, 0);
        chk("back_stall", fetch_stall_o, 0);
    endtask

    initial begin
        logic [OW-1:0] base;
        logic [DW-1:0] d;
        logic          st, fl;

        rst_ni = 1'b0; req_valid_i = 1'b0; req_store_i = 1'b0; req_offset_i = '0;
        issue_ack_i = 1'b0; busy_i = 1'b0; encrypting_i = 1'b0; decrypting_i = 1'b0;
        fail_i = 1'b0; cipher_data_i = '0;
        step();
        step();
        chk("rst_ready", req_ready_o, 1);
        chk("rst_stall", fetch_stall_o, 0);
        chk("rst_flags", {done_o, fail_o, timeout_o, encrypt_en_o, decrypt_en_o, store_en_o}, 0);
        chk("rst_data", data_o, 0);
        chk("rst_off", offset_o, 0);
        chk("rst_idx", chunk_idx_o, 0);
        rst_ni = 1'b1;

        // Plain load, then the same flow failing at decrypt end
        accept(0, 12'h010, 0);
        chunks(0, 12'h010, 1);
        decrypt(2, 1, 0, 32'hDEADBEEF);
        resp(32'hDEADBEEF, 0, 0);
        accept(0, 12'h010, 0);
        chunks(0, 12'h010, 1);
        decrypt(1, 2, 1, 32'h12345678);
        resp(32'h0, 1, 0);

        // Store behind a busy cipher
        accept(1, 12'h100, 3);
        encrypt(2);
        chunks(1, 12'h100, 1);
        resp(32'h0, 0, 0);

        // Offset wrap
        accept(0, 12'hFF8, 0);
        chunks(0, 12'hFF8, 1);
        decrypt(0, 0, 0, 32'hCAFEF00D);
        resp(32'hCAFEF00D, 0, 0);

        // Decrypt never starts
        accept(0, 12'h040, 0);
        chunks(0, 12'h040, 0);
        for (int k = 0; k < int'(TMO); k++) begin
            noise();
            decrypting_i = 1'b0;
            #1;
            check_busy("tmo_wait", 0, 1, 0);
            step();
        end
        resp(32'h0, 1, 1);

        // Reset during LOAD at chunk 2
        accept(0, 12'h200, 0);
        issue_ack_i = 1'b1;
        step();
        step();
        issue_ack_i = 1'b0;
        #1;
        chk("pre_rst_idx", chunk_idx_o, 2);
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        chk("mid_rst_ready", req_ready_o, 1);
        chk("mid_rst_off", offset_o, 0);
        chk("mid_rst_idx", chunk_idx_o, 0);
        chk("mid_rst_done", done_o, 0);
        chk("mid_rst_en", {encrypt_en_o, decrypt_en_o, store_en_o}, 0);
        chk("mid_rst_stall", fetch_stall_o, 0);

        // Randomized transactions
        for (int t = 0; t < 24; t++) begin
            st   = 1'($urandom);
            fl   = 1'($urandom);
            base = OW'($urandom);
            d    = DW'($urandom);
            accept(st, base, int'($urandom_range(0, 4)));
            if (st) begin
                encrypt(int'($urandom_range(0, 5)));
                chunks(1, base, 0);
                resp(32'h0, 0, 0);
            end else begin
                chunks(0, base, 0);
                decrypt(int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), fl, d);
                resp(fl ? 32'h0 : d, fl, 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sp_chunk_seq.md
SP_CHUNK_SEQ -- requirements
Module: sp_chunk_seq

Interface
REQ-001 SHALL have parameter NUM_CHUNKS, default 5: chunks per secure transfer, range 1..15.
REQ-002 SHALL have parameter CHUNK_STRIDE, default 8: byte offset increment between chunks.
REQ-003 SHALL have parameter OFFSET_W, default 12: offset width.
REQ-004 SHALL have parameter DATA_W, default 32: plaintext width.
REQ-005 SHALL have parameter TIMEOUT_CYC, default 64: cipher wait limit, ≥2.
REQ-006 SHALL have port clk_i, in, 1: the single clock.
REQ-007 SHALL have port rst_ni, in, 1: reset, synchronous and active-low.
REQ-008 SHALL have port req_valid_i, in, 1: secure load/store request from decode.
REQ-009 SHALL have port req_store_i, in, 1: 1 = secure store, 0 = secure load.
REQ-010 SHALL have port req_offset_i, in, OFFSET_W: base offset from the instruction immediate.
REQ-011 SHALL have port issue_ack_i, in, 1: issue stage accepted the current micro-op.
REQ-012 SHALL have cipher inputs busy_i, encrypting_i, decrypting_i, fail_i (1 each) and cipher_data_i (DATA_W).
REQ-013 SHALL have port req_ready_o, out, 1: high only in IDLE.
REQ-014 SHALL have port fetch_stall_o, out, 1: front-end stall.
REQ-015 SHALL have ports offset_o (OFFSET_W) and chunk_idx_o (4): current chunk address and index.
REQ-016 SHALL have outputs encrypt_en_o, decrypt_en_o and store_en_o (1 each).
REQ-017 SHALL have outputs done_o, fail_o and timeout_o (1 each) and data_o (DATA_W).

Function
REQ-018 SHALL implement the FSM states IDLE, WAIT_CIPHER, LOAD, DEC_START, DECRYPT, ENC_START, STORE and RESP.
REQ-019 IDLE: on req_valid_i, SHALL capture the op and offset, set idx=0, and go to WAIT_CIPHER if busy_i, else LOAD (load op) or ENC_START (store op).
REQ-020 IDLE: fetch_stall_o SHALL be high combinationally in the req_valid_i cycle.
REQ-021 WAIT_CIPHER: SHALL leave on the first cycle busy_i=0, to LOAD or ENC_START per the captured op.
REQ-022 LOAD: SHALL present offset_o and chunk_idx_o.
REQ-023 LOAD: on issue_ack_i with idx<NUM_CHUNKS-1, SHALL increment idx and add CHUNK_STRIDE to the offset, modulo 2^OFFSET_W.
REQ-024 LOAD: on issue_ack_i with idx=NUM_CHUNKS-1, SHALL go to DEC_START.
REQ-025 LOAD: with no issue_ack_i, SHALL hold state, idx and offset.
REQ-026 DEC_START: SHALL drive decrypt_en_o=1 until decrypting_i=1, then go to DECRYPT.
REQ-027 DECRYPT: on decrypting_i=0, SHALL register data_o=cipher_data_i if fail_i=0, else data_o=0 and fail_o=1, then go to RESP.
REQ-028 ENC_START: SHALL drive encrypt_en_o=1 until encrypting_i=1, then go to STORE with idx=0 and offset=base.
REQ-029 STORE: SHALL drive store_en_o=1 and step idx/offset on issue_ack_i exactly as in LOAD, going to RESP after the last chunk is acked.
REQ-030 In WAIT_CIPHER, DEC_START, DECRYPT and ENC_START, SHALL count cycles, clearing the count on each state entry.
REQ-031 When the count reaches TIMEOUT_CYC, SHALL go to RESP with timeout_o=1, fail_o=1 and data_o=0.
REQ-032 fetch_stall_o SHALL be 1 in every state except IDLE (per REQ-020) and RESP.
REQ-033 RESP: SHALL hold done_o=1 with data_o, fail_o and timeout_o stable, returning to IDLE on issue_ack_i.
REQ-034 SHALL clear fail_o, timeout_o and data_o on the next accepted request.
REQ-035 SHALL ignore req_valid_i outside IDLE; no queuing.
REQ-036 If req_valid_i and issue_ack_i coincide in IDLE, SHALL accept the request only, not advancing a chunk.
REQ-037 NUM_CHUNKS=1: LOAD/STORE SHALL last until the first ack only.

Reset
REQ-038 SHALL reset synchronously when rst_ni=0 at a clk_i edge: state IDLE, idx 0, offset 0, timeout count 0, data_o 0, all flags 0, req_ready_o 1.
REQ-039 Reset mid-operation SHALL abort with no done_o pulse and no enables asserted in the following cycle.

Verification
REQ-040 SHALL verify load: offset 0x010, busy_i=0, ack every cycle -> offset_o 0x010,0x018,0x020,0x028,0x030, then decrypt_en_o; decrypting_i 1→0 with data 0xDEADBEEF -> done_o, data_o=0xDEADBEEF, fail_o=0.
REQ-041 SHALL verify failure: same flow with fail_i=1 at decrypt end -> data_o=0, fail_o=1.
REQ-042 SHALL verify store: busy_i=1 for 3 cycles -> WAIT_CIPHER; encrypt_en_o held until encrypting_i, then 5 store_en_o acks, RESP, stall released.
REQ-043 SHALL verify wrap: offset 0xFF8 -> offsets 0xFF8,0x000,0x008,0x010,0x018.
REQ-044 SHALL verify timeout: decrypting_i never rises -> after 64 cycles in DEC_START, timeout_o=1, fail_o=1, done_o=1.
REQ-045 SHALL verify reset: rst_ni low during LOAD idx=2 -> next cycle IDLE, offset_o 0, req_ready_o 1, no done_o.
